gbuf_controller: RTL and testbench
==================================

Name: gbuf_controller

Overview:
- Initiator for the accelerator's global buffer. Drives its address / data-in / write-enable port and consumes its registered 8-bit read-back.
- Load mode: takes a byte stream over valid/ready and writes it to consecutive buffer addresses.
- Dump mode: reads a consecutive address range and emits the bytes as a valid/ready stream.
- Sits between the host-side byte link and the global buffer.

Parameters:
- ADDR_W, 10, width of buffer address bus and of base_addr/length.
- DATA_W, 8, buffer word width.
- DEPTH, 128, physical buffer locations; address pointer wraps DEPTH-1 -> 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = load, 1 = dump; sampled with start.
- base_addr  in  ADDR_W  first buffer address; sampled with start.
- length  in  ADDR_W  number of words to transfer; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when a command is rejected.
- s_valid  in  1  load stream valid.
- s_data  in  DATA_W  load stream data.
- s_ready  out  1  load stream ready.
- m_valid  out  1  dump stream valid.
- m_data  out  DATA_W  dump stream data.
- m_ready  in  1  dump stream ready.
- gb_address  out  ADDR_W  buffer address.
- gb_data_in  out  DATA_W  buffer write data.
- gb_write_enable  out  1  buffer write strobe.
- gb_rdata  in  DATA_W  buffer registered read data; valid one cycle after gb_address is presented.

Behaviour:
- Reset: state IDLE. busy, done, err, s_ready, m_valid, gb_write_enable = 0. gb_address, gb_data_in, m_data = 0. Applies mid-operation: the next edge clears everything, no further writes, and the partial transfer is abandoned (no done).
- All outputs are registered.
- States: IDLE, LOAD, DUMP_ISSUE, DUMP_WAIT, DUMP_OUT, DONE.
- IDLE, start=1:
  - If base_addr >= DEPTH or length > DEPTH: go to DONE with err=1, no buffer access.
  - Else if length == 0: go to DONE with err=0.
  - Else latch ptr = base_addr and cnt = length; go to LOAD (mode 0) or DUMP_ISSUE (mode 1).
- start outside IDLE is ignored.
- LOAD:
  - s_ready = 1 while cnt != 0.
  - A handshake (s_valid & s_ready) at edge T produces gb_write_enable=1, gb_address=ptr, gb_data_in=s_data in cycle T+1. Then ptr advances (wrapping DEPTH-1 -> 0) and cnt decrements.
  - gb_write_enable is low in every cycle without a preceding handshake.
  - On the last handshake, s_ready drops in the next cycle and state goes to DONE. The final write strobe and done are coincident.
- DUMP_ISSUE: drive gb_address = ptr; gb_write_enable = 0; go to DUMP_WAIT.
- DUMP_WAIT: gb_rdata now reflects ptr. Register it into m_data, set m_valid = 1, go to DUMP_OUT.
- DUMP_OUT:
  - Hold m_valid/m_data stable until m_ready.
  - On handshake: m_valid = 0, ptr advances with wrap, cnt decrements. If the new cnt == 0 go to DONE, else DUMP_ISSUE.
  - Throughput is 1 word per 3 cycles with no backpressure.
- DONE: done = 1 (err as decided) for exactly one cycle, then IDLE.
- gb_write_enable is never asserted in dump mode or in IDLE/DONE, except for the final load write coincident with done.
- No combinational path from s_valid to s_ready or from m_ready to m_valid.

Test Plan:
- Load, mode=0, base=5, length=4, bytes 0x11,0x22,0x33,0x44 offered back-to-back -> four single-cycle gb_write_enable pulses at addresses 5,6,7,8 with matching data. done pulse coincides with the 0x44 write. busy drops the next cycle.
- Load with s_valid gaps (valid every 3rd cycle), base=126, length=4 -> writes only on handshake+1, at addresses 126,127,0,1. No write during gaps.
- Dump, mode=1, base=5, length=4, after the load above, with m_ready low 5 cycles on the 2nd word -> stream 0x11,0x22,0x33,0x44. m_data stable while stalled. gb_write_enable never asserted.
- Reject cases:
  - base=128 -> done=err=1 one cycle after start, no buffer activity.
  - length=129 -> same.
  - length=0 -> done=1, err=0, no writes.
  - start pulsed while busy -> ignored.
- rst asserted after the 2nd of 4 load handshakes -> no further gb_write_enable; all outputs 0 next cycle; no done. A subsequent command then executes normally.

Source files
------------

// File: rtl/gbuf_if.sv
// Stream and global-buffer bus bundle for gbuf_controller.
// The master modport is the controller's side of the bundle; the slave modport is the host link and buffer side.
interface gbuf_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [ADDR_W-1:0] gb_address;
  logic [DATA_W-1:0] gb_data_in;
  logic              gb_write_enable;
  logic [DATA_W-1:0] gb_rdata;

  modport master (
    input  s_valid, s_data, m_ready, gb_rdata,
    output s_ready, m_valid, m_data, gb_address, gb_data_in, gb_write_enable
  );

  modport slave (
    output s_valid, s_data, m_ready, gb_rdata,
    input  s_ready, m_valid, m_data, gb_address, gb_data_in, gb_write_enable
  );
endinterface

// File: rtl/gbuf_controller.sv
// Global-buffer initiator. Load mode writes a byte stream to consecutive addresses.
// Dump mode reads a consecutive address range back out as a byte stream.
module gbuf_controller #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  gbuf_if.master            bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DUMP_ISSUE, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, ptr_inc;
  logic              busy_d, done_d, err_d;
  logic              s_ready_q, s_ready_d, m_valid_q, m_valid_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, m_data_q, m_data_d;

  logic cmd_bad, cmd_go, s_hs, m_hs, last;

  // Range checks are done one bit wider so DEPTH itself is representable.
  assign cmd_bad = ({1'b0, base_addr} >= DEPTH_X) || ({1'b0, length} > DEPTH_X);
  assign cmd_go  = start && !cmd_bad && (length != '0);
  assign s_hs    = bus.s_valid & s_ready_q;
  assign m_hs    = m_valid_q & bus.m_ready;
  assign last    = (cnt_q == ONE);
  assign ptr_inc = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ONE;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!cmd_go)   state_d = S_DONE;
          else if (mode) state_d = S_DUMP_ISSUE;
          else           state_d = S_LOAD;
        end
      end
      S_LOAD:       if (s_hs && last) state_d = S_DONE;
      S_DUMP_ISSUE: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT:  state_d = S_DUMP_OUT;
      S_DUMP_OUT:   if (m_hs) state_d = last ? S_DONE : S_DUMP_ISSUE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; they appear together with state_d.
  // NOTE: every signal assigned here gets a default first, so no latches are inferred.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    err_d     = 1'b0;
    s_ready_d = (state_d == S_LOAD);
    m_valid_d = (state_d == S_DUMP_OUT);
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    m_data_d  = m_data_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = start & cmd_bad;
        if (cmd_go) begin
          ptr_d = base_addr;
          cnt_d = length;
          // Dump presents the first address immediately so the read issues in DUMP_ISSUE.
          if (mode) addr_d = base_addr;
        end
      end
      S_LOAD: begin
        if (s_hs) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          din_d  = bus.s_data;
          ptr_d  = ptr_inc;
          cnt_d  = cnt_q - ONE;
        end
      end
      S_DUMP_WAIT: m_data_d = bus.gb_rdata;
      S_DUMP_OUT: begin
        if (m_hs) begin
          ptr_d  = ptr_inc;
          cnt_d  = cnt_q - ONE;
          addr_d = ptr_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      m_data_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      m_data_q  <= m_data_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.s_ready         = s_ready_q;
  assign bus.m_valid         = m_valid_q;
  assign bus.m_data          = m_data_q;
  assign bus.gb_address      = addr_q;
  assign bus.gb_data_in      = din_q;
  assign bus.gb_write_enable = we_q;

endmodule

// File: tb/tb_gbuf_controller.sv
// Directed bench for gbuf_controller: load, wrapped load, stalled dump, rejects, busy-start, mid-load reset.
// A small registered-read memory stands in for the global buffer.
module tb_gbuf_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [9:0] base_addr;
  logic [9:0] length;
  logic       busy, done, err;

  gbuf_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  gbuf_controller #(.ADDR_W(10), .DATA_W(8), .DEPTH(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [128];
  int         wr_count = 0;

  always @(posedge clk) begin
    if (bus.gb_write_enable) begin
      mem[bus.gb_address[6:0]] <= bus.gb_data_in;
      wr_count <= wr_count + 1;
    end
    bus.gb_rdata <= mem[bus.gb_address[6:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic m, input logic [9:0] b, input logic [9:0] l);
    start = 1'b1; mode = m; base_addr = b; length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.m_valid && n < 8) begin
      tick();
      n++;
    end
    check(tag, n, 2);
  endtask

  task automatic do_reject(input string tag, input logic [9:0] b, input logic [9:0] l, input logic e);
    int w0 = wr_count;
    start_cmd(1'b0, b, l);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, e);
    check({tag, "_sready"}, bus.s_ready, 0);
    tick();
    check({tag, "_idle"}, {busy, done, err}, 0);
    check({tag, "_nowr"}, wr_count, w0);
  endtask

  logic [7:0] d1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] d2 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
  logic [9:0] a2 [4] = '{10'd126, 10'd127, 10'd0, 10'd1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    tick(); tick();
    check("rst_ctrl", {busy, done, err, bus.s_ready, bus.m_valid, bus.gb_write_enable}, 0);
    check("rst_addr", bus.gb_address, 0);
    check("rst_data", {bus.gb_data_in, bus.m_data}, 0);
    rst = 1'b0;
    tick();

    // Back-to-back load at 5..8
    start_cmd(1'b0, 10'd5, 10'd4);
    check("ld1_busy", busy, 1);
    check("ld1_sready", bus.s_ready, 1);
    check("ld1_nowe", bus.gb_write_enable, 0);
    bus.s_valid = 1'b1; bus.s_data = d1[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ld1_we", bus.gb_write_enable, 1);
      check("ld1_addr", bus.gb_address, 5 + i);
      check("ld1_din", bus.gb_data_in, d1[i]);
      check("ld1_done", done, (i == 3) ? 1 : 0);
      check("ld1_sready_hs", bus.s_ready, (i == 3) ? 0 : 1);
      if (i < 3) bus.s_data = d1[i+1];
      else       bus.s_valid = 1'b0;
    end
    tick();
    check("ld1_end", {busy, done, bus.gb_write_enable}, 0);

    // Load with valid every third cycle, wrapping 127 -> 0
    start_cmd(1'b0, 10'd126, 10'd4);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_data = d2[i];
      tick();
      check("ld2_we", bus.gb_write_enable, 1);
      check("ld2_addr", bus.gb_address, a2[i]);
      check("ld2_din", bus.gb_data_in, d2[i]);
      check("ld2_done", done, (i == 3) ? 1 : 0);
      bus.s_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          check("ld2_gap_nowe", bus.gb_write_enable, 0);
        end
      end
    end
    tick();
    check("ld2_end", busy, 0);

    // Dump 5..8 with a five-cycle stall on the second word
    w0 = wr_count;
    bus.m_ready = 1'b1;
    start_cmd(1'b1, 10'd5, 10'd4);
    for (int w = 0; w < 4; w++) begin
      wait_valid("dmp_latency");
      check("dmp_data", bus.m_data, d1[w]);
      if (w == 1) begin
        bus.m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("dmp_stall_valid", bus.m_valid, 1);
          check("dmp_stall_data", bus.m_data, d1[w]);
        end
        bus.m_ready = 1'b1;
      end
      tick();
      check("dmp_valid_drop", bus.m_valid, 0);
      check("dmp_done", {done, err}, (w == 3) ? 2 : 0);
    end
    tick();
    check("dmp_end", busy, 0);
    check("dmp_nowr", wr_count, w0);
    bus.m_ready = 1'b0;

    // Rejected and empty commands
    do_reject("rej_base", 10'd128, 10'd4, 1'b1);
    do_reject("rej_len", 10'd0, 10'd129, 1'b1);
    do_reject("len0", 10'd3, 10'd0, 1'b0);

    // start while busy is ignored
    start_cmd(1'b0, 10'd20, 10'd2);
    start = 1'b1; mode = 1'b1; base_addr = 10'd0; length = 10'd1;
    tick();
    start = 1'b0;
    check("busy_start_state", {bus.s_ready, bus.m_valid, bus.gb_write_enable, done}, 4'b1000);
    bus.s_valid = 1'b1; bus.s_data = 8'h5C;
    tick();
    check("busy_start_wr0", {bus.gb_write_enable, bus.gb_address}, {1'b1, 10'd20});
    bus.s_data = 8'h5D;
    tick();
    check("busy_start_wr1", {bus.gb_write_enable, bus.gb_address, bus.gb_data_in}, {1'b1, 10'd21, 8'h5D});
    check("busy_start_done", done, 1);
    bus.s_valid = 1'b0;
    tick();
    check("busy_start_end", {busy, bus.m_valid}, 0);
    tick();
    check("busy_start_stays_idle", {busy, bus.m_valid, done}, 0);

    // Reset after two of four load handshakes
    start_cmd(1'b0, 10'd40, 10'd4);
    bus.s_valid = 1'b1; bus.s_data = 8'h71;
    tick();
    bus.s_data = 8'h72;
    tick();
    check("rstmid_wr2", {bus.gb_write_enable, bus.gb_address}, {1'b1, 10'd41});
    rst = 1'b1; bus.s_data = 8'h73;
    tick();
    w0 = wr_count;
    check("rstmid_ctrl", {busy, done, err, bus.s_ready, bus.m_valid, bus.gb_write_enable}, 0);
    check("rstmid_bus", {bus.gb_address, bus.gb_data_in, bus.m_data}, 0);
    tick();
    check("rstmid_hold", {bus.gb_write_enable, done}, 0);
    rst = 1'b0; bus.s_valid = 1'b0;
    tick();
    check("rstmid_nodone", {busy, done}, 0);
    check("rstmid_nowr", wr_count, w0);
    check("rstmid_mem42", mem[42], 8'h00);

    // Normal operation afterwards
    start_cmd(1'b0, 10'd60, 10'd1);
    bus.s_valid = 1'b1; bus.s_data = 8'h5A;
    tick();
    check("post_wr", {bus.gb_write_enable, bus.gb_address, bus.gb_data_in, done}, {1'b1, 10'd60, 8'h5A, 1'b1});
    bus.s_valid = 1'b0;
    tick();
    bus.m_ready = 1'b1;
    start_cmd(1'b1, 10'd60, 10'd1);
    wait_valid("post_dmp_latency");
    check("post_dmp_data", bus.m_data, 8'h5A);
    tick();
    check("post_dmp_done", {done, bus.m_valid}, 2'b10);
    tick();
    check("post_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
